// File: rtl/regfile_16_onehot_wr.sv
// -----------------------------------------------------------------------------
// regfile_16_onehot_wr
//
// 16-entry general-purpose register file driven by a one-hot write strobe
// (the output of the upstream 4x16 write-select decoder). Two read ports
// share one read enable and return registered data one cycle after the
// request. A write strobe with two or more bits set is rejected: no register
// changes and the sticky error flag is raised until the next reset.
//
// Optional feature (compile-time macro): REGFILE_BYPASS_EN
//   Defined   : a same-edge legal write to reg k and a read of addr k return
//               the incoming write data on that port (write-through).
//   Undefined : such a read returns the old register contents.
//
// Ports
//   clk_i        in   1           rising-edge clock
//   rst_ni       in   1           asynchronous active-low reset
//   wr_sel_i     in   NUM_REGS    one-hot write select
//   wr_data_i    in   DATA_WIDTH  write data
//   rd_en_i      in   1           read request for both ports
//   rd_addr_a_i  in   ADDR_WIDTH  read address, port A
//   rd_addr_b_i  in   ADDR_WIDTH  read address, port B
//   rd_data_a_o  out  DATA_WIDTH  registered read data, port A
//   rd_data_b_o  out  DATA_WIDTH  registered read data, port B
//   rd_valid_o   out  1           read data valid
//   err_o        out  1           sticky illegal-write-select flag
// -----------------------------------------------------------------------------
module regfile_16_onehot_wr #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG0  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REGS-1:0]   wr_sel_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b_i,
  output logic [DATA_WIDTH-1:0] rd_data_a_o,
  output logic [DATA_WIDTH-1:0] rd_data_b_o,
  output logic                  rd_valid_o,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(NUM_REGS + 1);

  // Number of set bits in the write strobe.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_data_a_r;
  logic [DATA_WIDTH-1:0] rd_data_b_r;
  logic                  rd_valid_r;
  logic                  err_r;

  logic [CNT_W-1:0]      wr_cnt_s;
  logic [ADDR_WIDTH-1:0] wr_idx_s;
  logic                  wr_multi_s;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] rd_val_a_s;
  logic [DATA_WIDTH-1:0] rd_val_b_s;

  // Decode the write strobe into a legal/illegal verdict and a register index.
  always_comb begin
    wr_cnt_s   = popcount(wr_sel_i);
    wr_idx_s   = '0;
    wr_multi_s = 1'b0;
    wr_en_s    = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_sel_i[k]) begin
        wr_idx_s = ADDR_WIDTH'(k);
      end else begin
        wr_idx_s = wr_idx_s;
      end
    end
    if (wr_cnt_s > CNT_W'(1)) begin
      wr_multi_s = 1'b1;
      wr_en_s    = 1'b0;
    end else if (wr_cnt_s == CNT_W'(1)) begin
      wr_multi_s = 1'b0;
      // A legal strobe to R0 is silently dropped when R0 is hardwired.
      if ((ZERO_REG0 != 0) && (wr_idx_s == '0)) begin
        wr_en_s = 1'b0;
      end else begin
        wr_en_s = 1'b1;
      end
    end else begin
      wr_multi_s = 1'b0;
      wr_en_s    = 1'b0;
    end
  end

  // Read-port muxes: zero register, optional write-through, else array contents.
  always_comb begin
    rd_val_a_s = regs_r[rd_addr_a_i];
    rd_val_b_s = regs_r[rd_addr_b_i];
`ifdef REGFILE_BYPASS_EN
    // wr_en_s already excludes illegal strobes and the hardwired R0.
    if (wr_en_s && (wr_idx_s == rd_addr_a_i)) begin
      rd_val_a_s = wr_data_i;
    end else begin
      rd_val_a_s = rd_val_a_s;
    end
    if (wr_en_s && (wr_idx_s == rd_addr_b_i)) begin
      rd_val_b_s = wr_data_i;
    end else begin
      rd_val_b_s = rd_val_b_s;
    end
`endif
    if ((ZERO_REG0 != 0) && (rd_addr_a_i == '0)) begin
      rd_val_a_s = '0;
    end else begin
      rd_val_a_s = rd_val_a_s;
    end
    if ((ZERO_REG0 != 0) && (rd_addr_b_i == '0)) begin
      rd_val_b_s = '0;
    end else begin
      rd_val_b_s = rd_val_b_s;
    end
  end

  // Register array update and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
      err_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        regs_r[wr_idx_s] <= wr_data_i;
      end
      if (wr_multi_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Registered read ports; data holds while no read is requested.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_a_r <= '0;
      rd_data_b_r <= '0;
      rd_valid_r  <= 1'b0;
    end else begin
      rd_valid_r <= rd_en_i;
      if (rd_en_i) begin
        rd_data_a_r <= rd_val_a_s;
        rd_data_b_r <= rd_val_b_s;
      end
    end
  end

  assign rd_data_a_o = rd_data_a_r;
  assign rd_data_b_o = rd_data_b_r;
  assign rd_valid_o  = rd_valid_r;
  assign err_o       = err_r;

endmodule
